// File: rtl/mem_rf_pkg.sv
// Shared types and helpers for the mem_rf_1w_nr register-file memory.
package mem_rf_pkg;

  typedef enum logic {
    MEM_RF_CLEAR = 1'b0,
    MEM_RF_READY = 1'b1
  } mem_rf_state_e;

  localparam int MEM_RF_MAX_NRD = 8;
  localparam int MEM_RF_MAX_AW  = 32;

  // Extract port idx's address from a zero-extended packed address bus.
  function automatic logic [MEM_RF_MAX_AW-1:0] mem_rf_addr_slice(
    input logic [MEM_RF_MAX_NRD*MEM_RF_MAX_AW-1:0] addrs,
    input int                                      idx,
    input int                                      aw
  );
    logic [MEM_RF_MAX_NRD*MEM_RF_MAX_AW-1:0] sh;
    logic [MEM_RF_MAX_AW-1:0]                mask;
    sh   = addrs >> (idx * aw);
    mask = (32'd1 << aw) - 32'd1;
    return sh[MEM_RF_MAX_AW-1:0] & mask;
  endfunction

endpackage

// File: rtl/mem_rf_rdport.sv
// One registered read port: enable, out-of-range zeroing, optional write-first
// forwarding when MEM_RF_1W_NR_BYPASS_EN is defined.
module mem_rf_rdport
  import mem_rf_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ready,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_raddr,
`ifdef MEM_RF_1W_NR_BYPASS_EN
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
`endif
  input  logic [WIDTH-1:0]  i_rf [DEPTH],
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] w_rdata_nxt;
  logic             w_in_range;

  assign w_in_range = (32'(i_raddr) < DEPTH);

  always_comb begin
    w_rdata_nxt = '0;
    if (w_in_range) begin
`ifdef MEM_RF_1W_NR_BYPASS_EN
      if (i_we && (i_waddr == i_raddr)) w_rdata_nxt = i_wdata;
      else                              w_rdata_nxt = i_rf[i_raddr];
`else
      w_rdata_nxt = i_rf[i_raddr];
`endif
    end
  end

  // Slice only updates in READY with its enable set; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset)                  r_rdata <= '0;
    else if (i_ready && i_ren)  r_rdata <= w_rdata_nxt;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_rf_1w_nr.sv
// Parametrised 1W/NRD-read register file with post-reset clear sweep.
// Optional write-first forwarding: define MEM_RF_1W_NR_BYPASS_EN.
module mem_rf_1w_nr
  import mem_rf_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [NRD-1:0]        ren,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*WIDTH-1:0]  rdata,
  output logic                  ready
);

  logic [WIDTH-1:0]  r_rf [DEPTH];
  mem_rf_state_e     r_state;
  mem_rf_state_e     w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              w_clr_last;
  logic              w_clr_en;
  logic              w_ready;
  logic              w_waddr_ok;

  assign w_clr_last = (r_clr_addr == ADDR_W'(DEPTH - 1));
  assign w_waddr_ok = (32'(waddr) < DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= MEM_RF_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_en && !w_clr_last) r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MEM_RF_CLEAR: if (w_clr_last) w_state_nxt = MEM_RF_READY;
      MEM_RF_READY: w_state_nxt = MEM_RF_READY;
      default:      w_state_nxt = MEM_RF_CLEAR;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == MEM_RF_READY);
    w_clr_en = (r_state == MEM_RF_CLEAR);
  end

  // The sweep owns the write port while clearing; user writes are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clr_en)                r_rf[r_clr_addr] <= '0;
      else if (we && w_waddr_ok)   r_rf[waddr]      <= wdata;
    end
  end

  logic [MEM_RF_MAX_NRD*MEM_RF_MAX_AW-1:0] w_raddr_ext;
  assign w_raddr_ext = {{(MEM_RF_MAX_NRD*MEM_RF_MAX_AW - NRD*ADDR_W){1'b0}}, raddr};

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic [WIDTH-1:0]  w_rdata;

    assign w_raddr = ADDR_W'(mem_rf_addr_slice(w_raddr_ext, gi, ADDR_W));

    mem_rf_rdport #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .clk     (clk),
      .reset   (reset),
      .i_ready (w_ready),
      .i_ren   (ren[gi]),
      .i_raddr (w_raddr),
`ifdef MEM_RF_1W_NR_BYPASS_EN
      .i_we    (we),
      .i_waddr (waddr),
      .i_wdata (wdata),
`endif
      .i_rf    (r_rf),
      .o_rdata (w_rdata)
    );

    assign rdata[gi*WIDTH +: WIDTH] = w_rdata;
  end

  assign ready = w_ready;

endmodule

// File: tb/tb_mem_rf_1w_nr.sv
// Directed self-checking bench for mem_rf_1w_nr (default 256x8/2R and a 10-deep/3R instance).
module tb_mem_rf_1w_nr;

  logic        clk = 1'b0;
  logic        reset, we, ready;
  logic [7:0]  waddr, wdata;
  logic [1:0]  ren;
  logic [15:0] raddr, rdata;

  logic        s_reset, s_we, s_ready;
  logic [3:0]  s_waddr;
  logic [7:0]  s_wdata;
  logic [2:0]  s_ren;
  logic [11:0] s_raddr;
  logic [23:0] s_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_rf_1w_nr #(.WIDTH(8), .DEPTH(256), .NRD(2)) u_dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata), .ready(ready)
  );

  mem_rf_1w_nr #(.WIDTH(8), .DEPTH(10), .NRD(3)) u_small (
    .clk(clk), .reset(s_reset), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .ren(s_ren), .raddr(s_raddr), .rdata(s_rdata), .ready(s_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; ren = 2'b11; raddr = 16'h0000;
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++;
    if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    n = 0;
    while (ready !== 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (n != 256) begin failures++; $display("FAIL sweep_len got=%0d exp=256", n); end
    checks++;
    if (rdata !== 16'h0000) begin failures++; $display("FAIL clear_rdata_held got=%h exp=0000", rdata); end
    for (int a = 0; a < 256; a++) begin
      raddr = {8'(255 - a), 8'(a)};
      tick();
      checks++;
      if (rdata !== 16'h0000) begin failures++; $display("FAIL cleared_read a=%0d got=%h exp=0000", a, rdata); end
    end
    ren = 2'b00;
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 8'h10; wdata = 8'hA5;
    tick();
    we = 1'b0; ren = 2'b11; raddr = 16'h1010;
    tick();
    checks++;
    if (rdata !== 16'hA5A5) begin failures++; $display("FAIL dual_read got=%h exp=a5a5", rdata); end
    ren = 2'b00;
  endtask

  task automatic test_rdw();
    logic [7:0] exp_first;
`ifdef MEM_RF_1W_NR_BYPASS_EN
    exp_first = 8'h3C;
`else
    exp_first = 8'h00;
`endif
    we = 1'b1; waddr = 8'h20; wdata = 8'h3C; ren = 2'b01; raddr = 16'h0020;
    tick();
    checks++;
    if (rdata[7:0] !== exp_first) begin failures++; $display("FAIL rdw_same_cycle got=%h exp=%h", rdata[7:0], exp_first); end
    we = 1'b0;
    tick();
    checks++;
    if (rdata[7:0] !== 8'h3C) begin failures++; $display("FAIL rdw_next_read got=%h exp=3c", rdata[7:0]); end
    ren = 2'b00;
  endtask

  task automatic test_hold();
    we = 1'b1; waddr = 8'h05; wdata = 8'h55;
    tick();
    we = 1'b0; ren = 2'b10; raddr = 16'h0500;
    tick();
    checks++;
    if (rdata[15:8] !== 8'h55) begin failures++; $display("FAIL hold_load got=%h exp=55", rdata[15:8]); end
    for (int k = 0; k < 4; k++) begin
      ren = 2'b01; raddr = {8'(8'h30 + k), 8'h10};
      tick();
      checks++;
      if (rdata !== 16'h55A5) begin failures++; $display("FAIL hold_k%0d got=%h exp=55a5", k, rdata); end
    end
    ren = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e0, e1;
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; waddr = 8'(8'h40 + k); wdata = 8'(8'h81 + k);
      ren = 2'b11;
      raddr = {8'(8'h40 + k), (k == 0) ? 8'h10 : 8'(8'h40 + k - 1)};
      tick();
      e0 = (k == 0) ? 8'hA5 : 8'(8'h81 + k - 1);
`ifdef MEM_RF_1W_NR_BYPASS_EN
      e1 = 8'(8'h81 + k);
`else
      e1 = 8'h00;
`endif
      checks++;
      if (rdata !== {e1, e0}) begin failures++; $display("FAIL b2b_k%0d got=%h exp=%h", k, rdata, {e1, e0}); end
    end
    we = 1'b0; ren = 2'b00;
  endtask

  task automatic test_reset_midsweep();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0; ren = 2'b11;
    for (int i = 0; i < 100; i++) begin
      we = 1'b1; waddr = 8'(i); wdata = 8'hFF; raddr = {8'(i), 8'(i)};
      tick();
    end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", ready); end
    checks++;
    if (rdata !== 16'h0000) begin failures++; $display("FAIL mid_rdata got=%h exp=0000", rdata); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      waddr = 8'(n); raddr = {8'(n), 8'(n)};
      tick(); n++;
    end
    we = 1'b0;
    checks++;
    if (n != 256) begin failures++; $display("FAIL restart_len got=%0d exp=256", n); end
    for (int a = 0; a < 256; a++) begin
      raddr = {8'(255 - a), 8'(a)};
      tick();
      checks++;
      if (rdata !== 16'h0000) begin failures++; $display("FAIL restart_read a=%0d got=%h exp=0000", a, rdata); end
    end
    ren = 2'b00;
  endtask

  task automatic test_small();
    int n;
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (n != 10) begin failures++; $display("FAIL small_sweep got=%0d exp=10", n); end
    s_we = 1'b1; s_waddr = 4'd12; s_wdata = 8'hEE;
    tick();
    s_we = 1'b1; s_waddr = 4'd9; s_wdata = 8'h7E; s_ren = 3'b001; s_raddr = 12'h00C;
    tick();
    checks++;
    if (s_rdata[7:0] !== 8'h00) begin failures++; $display("FAIL small_oob_read got=%h exp=00", s_rdata[7:0]); end
    s_we = 1'b0; s_ren = 3'b101; s_raddr = {4'd9, 4'd0, 4'd9};
    tick();
    checks++;
    if (s_rdata !== 24'h7E007E) begin failures++; $display("FAIL small_port2 got=%h exp=7e007e", s_rdata); end
    s_ren = 3'b001; s_raddr = {4'd0, 4'd0, 4'd15};
    tick();
    checks++;
    if (s_rdata !== 24'h7E0000) begin failures++; $display("FAIL small_oob_zero got=%h exp=7e0000", s_rdata); end
    s_ren = 3'b000;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
    s_reset = 1'b1; s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_ren = '0; s_raddr = '0;
    test_reset();
    test_write_read();
    test_rdw();
    test_hold();
    test_back_to_back();
    test_reset_midsweep();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
